// File: rtl/inside_scan_arbiter.sv
// Shared "key inside {table}" lookup engine: round-robin requester arbitration and a
// one-entry-per-cycle table scan. Define INSIDE_SCAN_EARLY_EXIT_EN to end a scan on its first hit.
module inside_scan_arbiter #(
  parameter  int DEPTH = 10,
  parameter  int WIDTH = 32,
  parameter  int NREQ  = 2,
  localparam int IW    = (DEPTH > 1) ? $clog2(DEPTH) : 1,
  localparam int RW    = (NREQ > 1) ? $clog2(NREQ) : 1
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  wr_en,
  input  logic [IW-1:0]         wr_addr,
  input  logic [WIDTH-1:0]      wr_data,
  input  logic                  clr,
  input  logic [NREQ-1:0]       req_valid,
  input  logic [NREQ*WIDTH-1:0] req_key,
  output logic [NREQ-1:0]       req_ready,
  output logic                  busy,
  output logic                  rsp_valid,
  output logic [RW-1:0]         rsp_id,
  output logic                  rsp_hit,
  output logic [IW-1:0]         rsp_index
);

  typedef enum logic [1:0] {IDLE, SCAN, DONE} state_e;

  state_e               state_q, state_d;
  logic [IW-1:0]        idx_q, idx_d;
  logic [WIDTH-1:0]     key_q, key_d;
  logic [RW-1:0]        owner_q, owner_d;
  logic [RW-1:0]        rr_ptr_q, rr_ptr_d;
  logic                 hit_q, hit_d;
  logic [IW-1:0]        hit_idx_q, hit_idx_d;
  logic [NREQ-1:0]      req_ready_q, req_ready_d;
  logic                 busy_q, busy_d;
  logic                 rsp_valid_q, rsp_valid_d;
  logic [RW-1:0]        rsp_id_q, rsp_id_d;
  logic                 rsp_hit_q, rsp_hit_d;
  logic [IW-1:0]        rsp_index_q, rsp_index_d;

  logic [DEPTH-1:0]     valid_q;
  logic [WIDTH-1:0]     data_q [DEPTH];

  logic                 wr_ok;
  logic                 entry_match;
  logic                 last_entry;
  logic                 scan_done;
  logic                 arb_found;
  logic [RW-1:0]        arb_gnt;
  logic                 grant;

  // ---------------------------------------------------------------- table
  assign wr_ok = wr_en && ({1'b0, wr_addr} < (IW+1)'(DEPTH));

  // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      valid_q <= '0;
    end else if (clr) begin
      valid_q <= '0;
    end else if (wr_ok) begin
      valid_q[wr_addr] <= 1'b1;
    end
  end

  // NOTE: table data carries no reset; the valid bits alone define an empty table.
  always_ff @(posedge clk) begin
    if (wr_ok) begin
      data_q[wr_addr] <= wr_data;
    end
  end

  // ---------------------------------------------------------------- arbitration
  always_comb begin
    int j;
    j         = 0;
    arb_found = 1'b0;
    arb_gnt   = '0;
    for (int k = 0; k < NREQ; k++) begin
      j = (int'(rr_ptr_q) + k) % NREQ;
      if (!arb_found && req_valid[j]) begin
        arb_found = 1'b1;
        arb_gnt   = RW'(j);
      end
    end
  end

  // ---------------------------------------------------------------- scan datapath
  assign entry_match = valid_q[idx_q] && (data_q[idx_q] == key_q);
  assign last_entry  = (idx_q == IW'(DEPTH - 1));

`ifdef INSIDE_SCAN_EARLY_EXIT_EN
  assign scan_done = last_entry || entry_match;
`else
  assign scan_done = last_entry;
`endif

  // The grant is decided one cycle ahead so req_ready can be a registered pulse;
  // the accept cycle itself is spent in IDLE with req_ready_q high.
  assign grant = arb_found &&
                 (((state_q == IDLE) && (req_ready_q == '0)) || (state_q == DONE));

  // NOTE: every next-state signal gets its default first so no path infers a latch.
  always_comb begin
    state_d     = state_q;
    idx_d       = idx_q;
    key_d       = key_q;
    owner_d     = owner_q;
    rr_ptr_d    = rr_ptr_q;
    hit_d       = hit_q;
    hit_idx_d   = hit_idx_q;
    req_ready_d = '0;
    rsp_valid_d = 1'b0;
    rsp_id_d    = rsp_id_q;
    rsp_hit_d   = rsp_hit_q;
    rsp_index_d = rsp_index_q;

    case (state_q)
      IDLE: begin
        if (req_ready_q != '0) begin
          state_d = SCAN;
        end
      end
      SCAN: begin
        if (entry_match && !hit_q) begin
          hit_d     = 1'b1;
          hit_idx_d = idx_q;
        end
        if (scan_done) begin
          state_d     = DONE;
          rsp_valid_d = 1'b1;
          rsp_id_d    = owner_q;
          rsp_hit_d   = hit_q || entry_match;
          rsp_index_d = hit_q ? hit_idx_q : (entry_match ? idx_q : '0);
        end else begin
          idx_d = idx_q + 1'b1;
        end
      end
      DONE: begin
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase

    if (grant) begin
      req_ready_d[arb_gnt] = 1'b1;
      key_d                = req_key[int'(arb_gnt)*WIDTH +: WIDTH];
      owner_d              = arb_gnt;
      rr_ptr_d             = RW'((int'(arb_gnt) + 1) % NREQ);
      idx_d                = '0;
      hit_d                = 1'b0;
      hit_idx_d            = '0;
    end

    busy_d = (state_d != IDLE);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= IDLE;
      idx_q       <= '0;
      key_q       <= '0;
      owner_q     <= '0;
      rr_ptr_q    <= '0;
      hit_q       <= 1'b0;
      hit_idx_q   <= '0;
      req_ready_q <= '0;
      busy_q      <= 1'b0;
      rsp_valid_q <= 1'b0;
      rsp_id_q    <= '0;
      rsp_hit_q   <= 1'b0;
      rsp_index_q <= '0;
    end else begin
      state_q     <= state_d;
      idx_q       <= idx_d;
      key_q       <= key_d;
      owner_q     <= owner_d;
      rr_ptr_q    <= rr_ptr_d;
      hit_q       <= hit_d;
      hit_idx_q   <= hit_idx_d;
      req_ready_q <= req_ready_d;
      busy_q      <= busy_d;
      rsp_valid_q <= rsp_valid_d;
      rsp_id_q    <= rsp_id_d;
      rsp_hit_q   <= rsp_hit_d;
      rsp_index_q <= rsp_index_d;
    end
  end

  assign req_ready = req_ready_q;
  assign busy      = busy_q;
  assign rsp_valid = rsp_valid_q;
  assign rsp_id    = rsp_id_q;
  assign rsp_hit   = rsp_hit_q;
  assign rsp_index = rsp_index_q;

endmodule

// File: tb/tb_inside_scan_arbiter.sv
// Directed bench for inside_scan_arbiter: lookups, duplicates, round-robin, writes/clear
// during a scan, reset mid-scan and out-of-range writes, with hand-computed expectations.
module tb_inside_scan_arbiter;

  localparam int DEPTH = 10;
  localparam int WIDTH = 32;
  localparam int NREQ  = 2;
  localparam int IW    = 4;
  localparam int RW    = 1;
`ifdef INSIDE_SCAN_EARLY_EXIT_EN
  localparam bit EARLY = 1'b1;
`else
  localparam bit EARLY = 1'b0;
`endif

  logic                  clk = 1'b0;
  logic                  rst_n = 1'b0;
  logic                  wr_en = 1'b0;
  logic [IW-1:0]         wr_addr = '0;
  logic [WIDTH-1:0]      wr_data = '0;
  logic                  clr = 1'b0;
  logic [NREQ-1:0]       req_valid = '0;
  logic [NREQ*WIDTH-1:0] req_key = '0;
  logic [NREQ-1:0]       req_ready;
  logic                  busy;
  logic                  rsp_valid;
  logic [RW-1:0]         rsp_id;
  logic                  rsp_hit;
  logic [IW-1:0]         rsp_index;

  int vec_cnt = 0;
  int err_cnt = 0;

  inside_scan_arbiter #(.DEPTH(DEPTH), .WIDTH(WIDTH), .NREQ(NREQ)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .wr_en     (wr_en),
    .wr_addr   (wr_addr),
    .wr_data   (wr_data),
    .clr       (clr),
    .req_valid (req_valid),
    .req_key   (req_key),
    .req_ready (req_ready),
    .busy      (busy),
    .rsp_valid (rsp_valid),
    .rsp_id    (rsp_id),
    .rsp_hit   (rsp_hit),
    .rsp_index (rsp_index)
  );

  always #5 clk = ~clk;

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    vec_cnt++;
    if (got !== exp) begin
      err_cnt++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  function automatic int exp_lat(input bit hit, input int idx);
    return (EARLY && hit) ? idx + 2 : DEPTH + 1;
  endfunction

  task automatic check_quiet(input string tag);
    check({tag, "_ready"}, req_ready, 0);
    check({tag, "_busy"},  busy,      0);
    check({tag, "_rspv"},  rsp_valid, 0);
    check({tag, "_id"},    rsp_id,    0);
    check({tag, "_hit"},   rsp_hit,   0);
    check({tag, "_index"}, rsp_index, 0);
  endtask

  task automatic write_entry(input int addr, input logic [WIDTH-1:0] data);
    @(negedge clk);
    wr_en = 1'b1; wr_addr = IW'(addr); wr_data = data;
    @(negedge clk);
    wr_en = 1'b0;
  endtask

  task automatic clear_table();
    @(negedge clk);
    clr = 1'b1;
    @(negedge clk);
    clr = 1'b0;
  endtask

  // Issues one query and optionally drives a write or clear c cycles after accept
  // (c = 1 is the cycle comparing entry 0).
  task automatic query(input string tag, input int id, input logic [WIDTH-1:0] key,
                       input bit exp_hit, input int exp_idx,
                       input int mid_c = -1, input int mid_addr = 0,
                       input logic [WIDTH-1:0] mid_data = '0);
    bit seen;
    int c;
    @(negedge clk);
    req_valid[id] = 1'b1;
    req_key[id*WIDTH +: WIDTH] = key;
    seen = 1'b0;
    for (int i = 0; i < 40 && !seen; i++) begin
      @(negedge clk);
      seen = (req_ready != '0);
    end
    check({tag, "_accept"}, seen, 1);
    check({tag, "_grant"}, req_ready, 64'(1) << id);
    req_valid[id] = 1'b0;
    seen = 1'b0;
    c = 0;
    while (!seen && c < 40) begin
      @(negedge clk);
      c++;
      wr_en = 1'b0;
      if (c == mid_c) begin
        wr_en = 1'b1; wr_addr = IW'(mid_addr); wr_data = mid_data;
      end
      seen = rsp_valid;
    end
    wr_en = 1'b0;
    check({tag, "_rsp_seen"}, seen, 1);
    check({tag, "_latency"}, c, exp_lat(exp_hit, exp_idx));
    check({tag, "_hit"}, rsp_hit, exp_hit);
    check({tag, "_index"}, rsp_index, exp_idx);
    check({tag, "_id"}, rsp_id, id);
    check({tag, "_busy"}, busy, 1);
  endtask

  initial begin
    int ng;
    int nr;
    int c;
    bit rsp_flag;
    bit seen;

    // Reset state
    repeat (3) @(negedge clk);
    check_quiet("reset");
    rst_n = 1'b1;

    // Single lookups
    write_entry(0, 32'd10);
    write_entry(1, 32'd20);
    write_entry(9, 32'd90);
    query("q10", 0, 32'd10, 1'b1, 0);
    query("q20", 0, 32'd20, 1'b1, 1);
    query("q90", 0, 32'd90, 1'b1, 9);
    query("q99", 0, 32'd99, 1'b0, 0);

    // Duplicates: lowest index wins
    write_entry(3, 32'd55);
    write_entry(7, 32'd55);
    query("dup55", 0, 32'd55, 1'b1, 3);

    // Out-of-range write is ignored, table intact
    write_entry(12, 32'd123);
    query("oor123", 0, 32'd123, 1'b0, 0);
    query("oor10",  0, 32'd10,  1'b1, 0);
    query("oor90",  0, 32'd90,  1'b1, 9);
    query("oor55",  0, 32'd55,  1'b1, 3);

    // Round-robin with both requesters held from reset
    @(negedge clk);
    rst_n = 1'b0;
    req_valid = '1;
    req_key = {32'd20, 32'd10};
    repeat (2) @(negedge clk);
    rst_n = 1'b1; wr_en = 1'b1; wr_addr = 4'd0; wr_data = 32'd10;
    ng = 0; nr = 0;
    for (int cyc = 1; cyc <= 200 && nr < 4; cyc++) begin
      @(negedge clk);
      if (cyc == 1) begin wr_addr = 4'd1; wr_data = 32'd20; end
      if (cyc == 2) wr_en = 1'b0;
      if (req_ready != '0) begin
        check($sformatf("rr_grant%0d", ng), req_ready, 64'(1) << (ng % 2));
        ng++;
      end
      if (rsp_valid) begin
        check($sformatf("rr_id%0d", nr), rsp_id, nr % 2);
        check($sformatf("rr_hit%0d", nr), rsp_hit, 1);
        check($sformatf("rr_index%0d", nr), rsp_index, nr % 2);
        nr++;
        if (nr == 4) req_valid = '0;
      end
    end
    wr_en = 1'b0;
    req_valid = '0;
    check("rr_grants", ng, 4);
    check("rr_rsps", nr, 4);
    repeat (3) @(negedge clk);
    check("rr_idle", busy, 0);

    // Write during scan: ahead of the scan is seen, behind it is not
    clear_table();
    query("wr_ahead", 0, 32'd77, 1'b1, 8, 3, 8, 32'd77);
    clear_table();
    query("wr_behind", 0, 32'd77, 1'b0, 0, 5, 1, 32'd77);

    // clr beats a same-cycle write
    @(negedge clk);
    clr = 1'b1; wr_en = 1'b1; wr_addr = 4'd0; wr_data = 32'd5;
    @(negedge clk);
    clr = 1'b0; wr_en = 1'b0;
    query("clr_wr5", 0, 32'd5, 1'b0, 0);

    // Reset in the middle of a scan
    write_entry(0, 32'd10);
    @(negedge clk);
    req_valid[0] = 1'b1;
    req_key[0 +: WIDTH] = 32'd99;
    seen = 1'b0;
    for (int i = 0; i < 40 && !seen; i++) begin
      @(negedge clk);
      seen = (req_ready != '0);
    end
    check("rst_accept", seen, 1);
    req_valid = '0;
    rsp_flag = 1'b0;
    for (c = 1; c <= 6; c++) begin
      @(negedge clk);
      if (rsp_valid) rsp_flag = 1'b1;
    end
    check("rst_scan_busy", busy, 1);
    rst_n = 1'b0;
    #1;
    check_quiet("rst_mid");
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    for (int i = 0; i < 15; i++) begin
      @(negedge clk);
      if (rsp_valid) rsp_flag = 1'b1;
    end
    check("rst_no_rsp", rsp_flag, 0);
    query("rst_q10", 0, 32'd10, 1'b0, 0);

    $display("== %0d vectors applied, %0d miscompares ==", vec_cnt, err_cnt);
    $finish;
  end

endmodule

// File: doc/inside_scan_arbiter.md
# inside_scan_arbiter

Shared set-membership lookup engine: holds a DEPTH-entry table of WIDTH-bit values and answers "key inside {table}" queries from NREQ requesters. It round-robin arbitrates between requesters and scans the table sequentially, one entry per cycle, through a single comparator. It sits beside the array-membership datapath as its sequencer and sharing point, so one comparator and one table serve all clients.

## Interface
- DEPTH, 10: number of table entries (≥2).
- WIDTH, 32: entry/key width in bits.
- NREQ, 2: number of requesters (≥1).
- IW = $clog2(DEPTH), RW = $clog2(NREQ) (min 1): derived widths.

- clk  in  1  sole clock, rising edge.
- rst_n  in  1  asynchronous, active-low reset.
- wr_en  in  1  write table entry this cycle.
- wr_addr  in  IW  entry index; writes with wr_addr ≥ DEPTH are ignored.
- wr_data  in  WIDTH  value written; the entry's valid bit is set.
- clr  in  1  clear all valid bits; takes priority over a same-cycle wr_en.
- req_valid  in  NREQ  per-requester query pending; held until accepted.
- req_key  in  NREQ*WIDTH  per-requester key, requester i at bits [i*WIDTH +: WIDTH].
- req_ready  out  NREQ  one-hot accept pulse, one cycle.
- busy  out  1  engine not in IDLE.
- rsp_valid  out  1  response pulse, one cycle.
- rsp_id  out  RW  requester that owns the response.
- rsp_hit  out  1  key found in a valid entry.
- rsp_index  out  IW  lowest matching index; 0 when rsp_hit=0.

## Operation
- Table: DEPTH registers plus valid bits.
  - Writes take effect at the clock edge.
  - The comparator reads registered contents, so a same-cycle write to the entry being compared is not seen.
- FSM with three states: IDLE, SCAN, DONE.
  - IDLE: if any req_valid bit is set, grant requester g, the first set bit at or after rr_ptr (wrapping). Pulse req_ready[g], latch the key and g, clear idx and the hit flag, set rr_ptr = (g+1) mod NREQ, go to SCAN.
  - SCAN: compare entry idx (valid && data == key). On the first match, record hit=1 and index=idx; later matches do not overwrite it. If idx == DEPTH-1, go to DONE; otherwise idx++.
  - DONE: rsp_valid=1 with rsp_id, rsp_hit, rsp_index; return to IDLE.
- No request is accepted outside IDLE. req_valid bits that drop before acceptance are simply not served.
- Entries already passed by the scan are not re-examined after a write. clr mid-scan affects only the remaining entries.
- Reset mid-operation aborts the query with no response. Reset values:
  - req_ready=0, rsp_valid=0, rsp_id=0, rsp_hit=0, rsp_index=0, busy=0.
  - All valid bits 0, rr_ptr=0, FSM in IDLE.
  - Table data contents are don't-care.

## Timing
- Accept in cycle N (req_ready high).
- Full scan: SCAN covers cycles N+1..N+DEPTH; rsp_valid is high in cycle N+DEPTH+1.
- The next accept is possible at cycle N+DEPTH+2, giving a throughput of one query per DEPTH+2 cycles.
- busy is high from cycle N+1 through the rsp_valid cycle inclusive.
- All outputs are registered. No combinational path from inputs to outputs.

## Configuration
- INSIDE_SCAN_EARLY_EXIT_EN defined:
  - SCAN goes to DONE in the cycle it finds the first match at index k, so rsp_valid is high at N+k+2.
  - A miss still takes the full DEPTH cycles.
- Not defined:
  - Every query scans all DEPTH entries, giving constant latency DEPTH+1.
  - Response values are identical either way; only the timing differs.

## Test plan
- Single lookup:
  - Stimulus: write [0]=10, [1]=20, [9]=90; requester 0 queries 10, 20, 90 and 99.
  - Response: hit=1 at index 0, 1 and 9; hit=0 with index 0 for 99. Latency is 11 cycles from accept to rsp_valid, or 2, 3 and 11 for the hits under early exit.
- Duplicates:
  - Stimulus: [3]=[7]=55; query 55.
  - Response: rsp_index=3, rsp_hit=1.
- Round-robin:
  - Stimulus: both requesters hold req_valid continuously from reset.
  - Response: grants alternate 0,1,0,1; each rsp_id matches its grant.
- Write and clear during scan:
  - Stimulus: query 77 on an empty table; write [8]=77 during SCAN at idx 2; rerun with a write of [1]=77 at idx 4.
  - Response: hit at 8 in the first run; miss in the second. Then clr with a same-cycle write [0]=5, and query 5: miss.
- Reset mid-scan:
  - Stimulus: assert rst_n low at SCAN idx 5.
  - Response: no rsp_valid; all outputs and busy are 0; the table is empty afterwards, so query 10 misses.
- Out-of-range write:
  - Stimulus: wr_addr=12 with DEPTH=10, then query that value.
  - Response: miss; the table is unchanged.
